// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between the PC/address path (id 0) and the execute path (id 1).
// Optional grant counters are enabled with ALU_ARB_PERF_EN.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_overflow,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last_grant;
  logic       id_q;
  logic       grant0_c;
  logic       grant1_c;
  logic       accept_c;

  // Requester 1 wins on its own, or on contention when requester 0 was served last.
  always_comb begin
    grant1_c = req1_valid && (!req0_valid || !last_grant);
    grant0_c = req0_valid && !grant1_c;
  end

  // Ready is suppressed during reset so no handshake can be lost to the reset edge.
  assign req0_ready = !rst && (state == IDLE) && grant0_c;
  assign req1_ready = !rst && (state == IDLE) && grant1_c;
  assign accept_c   = req0_ready || req1_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_valid && resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch doubles as the registered ALU drive; it only changes on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant    <= 1'b1;
      id_q          <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= '0;
      resp_valid    <= 1'b0;
      resp_id       <= 1'b0;
      resp_result   <= '0;
      resp_zero     <= 1'b0;
      resp_overflow <= 1'b0;
    end else begin
      if (accept_c) begin
        alu_a      <= req1_ready ? req1_a  : req0_a;
        alu_b      <= req1_ready ? req1_b  : req0_b;
        alu_op     <= req1_ready ? req1_op : req0_op;
        id_q       <= req1_ready;
        last_grant <= req1_ready;
      end
      if (state == EXEC) begin
        resp_result   <= alu_result;
        resp_zero     <= alu_zero;
        resp_overflow <= alu_overflow;
        resp_id       <= id_q;
      end
      resp_valid <= (state_nxt == RESP);
    end
  end

`ifdef ALU_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= 16'd0;
      grant_cnt1 <= 16'd0;
    end else begin
      if (req0_ready) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req1_ready) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule
